// File: rtl/conv_1x1_sched_pkg.sv
// Shared definitions for the 1x1 convolution scheduler: FSM states, width helper
// and the derived widths of the default configuration.
package conv_1x1_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VEC = 2'd1,
        RUN      = 2'd2,
        FIN      = 2'd3
    } state_t;

    // Ceiling log2, never below 1 so degenerate counts still yield a legal vector.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    localparam int unsigned DEF_IMAGE_WIDTH     = 64;
    localparam int unsigned DEF_IMAGE_HEIGHT    = 64;
    localparam int unsigned DEF_CHANNEL_NUM_IN  = 256;
    localparam int unsigned DEF_CHANNEL_NUM_OUT = 48;
    localparam int unsigned CI_W  = clog2(DEF_CHANNEL_NUM_IN);
    localparam int unsigned CO_W  = clog2(DEF_CHANNEL_NUM_OUT);
    localparam int unsigned WA_W  = clog2(DEF_CHANNEL_NUM_IN * DEF_CHANNEL_NUM_OUT);
    localparam int unsigned PIX_W = clog2(DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT);

endpackage

// File: rtl/conv_nested_cnt.sv
// Two-level wrap counter (inner x outer) with a linear address that tracks
// outer*INNER_N + inner by incrementing, so no multiplier is needed.
module conv_nested_cnt
    import conv_1x1_sched_pkg::*;
#(
    parameter int unsigned INNER_N = 256,
    parameter int unsigned OUTER_N = 48,
    parameter int unsigned IW      = clog2(INNER_N),
    parameter int unsigned OW      = clog2(OUTER_N),
    parameter int unsigned AW      = clog2(INNER_N * OUTER_N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [IW-1:0] inner,
    output logic [OW-1:0] outer,
    output logic [AW-1:0] addr,
    output logic          inner_last,
    output logic          outer_last
);

    logic [IW-1:0] inner_q, inner_d;
    logic [OW-1:0] outer_q, outer_d;
    logic [AW-1:0] addr_q, addr_d;

    assign inner_last = (inner_q == IW'(INNER_N - 1));
    assign outer_last = (outer_q == OW'(OUTER_N - 1));

    always_comb begin
        inner_d = inner_q;
        outer_d = outer_q;
        addr_d  = addr_q;
        if (clr) begin
            inner_d = '0;
            outer_d = '0;
            addr_d  = '0;
        end else if (en) begin
            if (inner_last) begin
                inner_d = '0;
                if (outer_last) begin
                    outer_d = '0;
                    addr_d  = '0;
                end else begin
                    outer_d = outer_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                end
            end else begin
                inner_d = inner_q + 1'b1;
                addr_d  = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inner_q <= '0;
            outer_q <= '0;
            addr_q  <= '0;
        end else begin
            inner_q <= inner_d;
            outer_q <= outer_d;
            addr_q  <= addr_d;
        end
    end

    assign inner = inner_q;
    assign outer = outer_q;
    assign addr  = addr_q;

endmodule

// File: rtl/conv_1x1_sched.sv
// Per-pixel sequencer for the 1x1 convolution datapath: walks co (outer) x ci (inner)
// on a valid/ready handshake, releases each pixel vector and pulses done at frame end.
module conv_1x1_sched
    import conv_1x1_sched_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH     = 64,
    parameter int unsigned IMAGE_HEIGHT    = 64,
    parameter int unsigned CHANNEL_NUM_IN  = 256,
    parameter int unsigned CHANNEL_NUM_OUT = 48,
    parameter int unsigned CI_W  = clog2(CHANNEL_NUM_IN),
    parameter int unsigned CO_W  = clog2(CHANNEL_NUM_OUT),
    parameter int unsigned WA_W  = clog2(CHANNEL_NUM_IN * CHANNEL_NUM_OUT),
    parameter int unsigned PIX_W = clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            vec_ready,
    input  logic            mac_ready,
    output logic [CI_W-1:0] pxl_rd_addr,
    output logic [WA_W-1:0] wgt_rd_addr,
    output logic [CO_W-1:0] out_ch,
    output logic            mac_valid,
    output logic            mac_first,
    output logic            mac_last,
    output logic            vec_release,
    output logic            busy,
    output logic            done
);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             busy_q, busy_d;
    logic             vec_release_q, vec_release_d;
    logic             done_q, done_d;

    logic            in_run, accept, cnt_clr;
    logic            inner_last, outer_last;
    logic [CI_W-1:0] ci;
    logic [CO_W-1:0] co;
    logic [WA_W-1:0] wa;

    assign in_run = (state_q == RUN);
    assign accept = in_run && mac_ready;

    conv_nested_cnt #(
        .INNER_N (CHANNEL_NUM_IN),
        .OUTER_N (CHANNEL_NUM_OUT),
        .IW      (CI_W),
        .OW      (CO_W),
        .AW      (WA_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr        (cnt_clr),
        .en         (accept),
        .inner      (ci),
        .outer      (co),
        .addr       (wa),
        .inner_last (inner_last),
        .outer_last (outer_last)
    );

    always_comb begin
        state_d       = state_q;
        pix_d         = pix_q;
        busy_d        = busy_q;
        vec_release_d = 1'b0;
        done_d        = 1'b0;
        cnt_clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_VEC;
                    busy_d  = 1'b1;
                    pix_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            WAIT_VEC: begin
                if (vec_ready) state_d = RUN;
            end
            RUN: begin
                if (accept && inner_last && outer_last) begin
                    vec_release_d = 1'b1;
                    if (pix_q == PIX_LAST) begin
                        state_d = FIN;
                    end else begin
                        pix_d   = pix_q + 1'b1;
                        state_d = WAIT_VEC;
                    end
                end
            end
            FIN: begin
                // done is registered so it lands one cycle after the final vec_release.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pix_q         <= '0;
            busy_q        <= 1'b0;
            vec_release_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            busy_q        <= busy_d;
            vec_release_q <= vec_release_d;
            done_q        <= done_d;
        end
    end

    assign pxl_rd_addr = ci;
    assign out_ch      = co;
    assign wgt_rd_addr = wa;
    assign mac_valid   = in_run;
    assign mac_first   = in_run && (ci == '0);
    assign mac_last    = in_run && inner_last;
    assign vec_release = vec_release_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
